// File: rtl/dcache_ctrl.sv
// Data-cache controller: load hit/miss handling, write-through/write-allocate
// stores, and hit/miss statistics between the LSU, dcachemem and memory bus.
module dcache_ctrl #(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                proc_req,
    input  logic                proc_wr,
    input  logic [63:0]         proc_addr,
    input  logic [63:0]         proc_wr_data,
    output logic                proc_done,
    output logic [63:0]         proc_rd_data,
    output logic [1:0]          proc2mem_command,
    output logic [63:0]         proc2mem_addr,
    output logic [63:0]         proc2mem_data,
    input  logic [3:0]          mem2proc_response,
    input  logic [63:0]         mem2proc_data,
    input  logic [3:0]          mem2proc_tag,
    output logic                cache_en,
    output logic                cache_wr_en,
    output logic [IDX_BITS-1:0] cache_wr_idx,
    output logic [IDX_BITS-1:0] cache_rd_idx,
    output logic [TAG_BITS-1:0] cache_wr_tag,
    output logic [TAG_BITS-1:0] cache_rd_tag,
    output logic [63:0]         cache_wr_data,
    input  logic [63:0]         cache_rd_data,
    input  logic                cache_rd_valid,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MREQ  = 2'd1;
    localparam logic [1:0] MWAIT = 2'd2;
    localparam logic [1:0] SREQ  = 2'd3;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [63:3] addr_q;
    logic [63:0] data_q;
    logic [3:0]  pend_tag_q;
    logic [3:0]  pend_tag_d;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        latch_req;
    logic        hit_inc;
    logic        miss_inc;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^proc_addr[2:0];

    assign cache_rd_idx = proc_addr[IDX_BITS+2:3];
    assign cache_rd_tag = proc_addr[TAG_BITS+IDX_BITS+2:IDX_BITS+3];
    assign cache_wr_idx = addr_q[IDX_BITS+2:3];
    assign cache_wr_tag = addr_q[TAG_BITS+IDX_BITS+2:IDX_BITS+3];

    assign proc2mem_addr = {addr_q, 3'b000};
    assign proc2mem_data = data_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

    always_comb begin
        state_d          = state_q;
        pend_tag_d       = pend_tag_q;
        proc_done        = 1'b0;
        proc_rd_data     = 64'd0;
        proc2mem_command = CMD_NONE;
        cache_en         = 1'b0;
        cache_wr_en      = 1'b0;
        cache_wr_data    = data_q;
        latch_req        = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        unique case (state_q)
            IDLE: begin
                // IDLE outputs follow inputs, so hold them quiet in reset
                if (proc_req && !reset) begin
                    if (!proc_wr) begin
                        cache_en = 1'b1;
                        if (cache_rd_valid) begin
                            proc_done    = 1'b1;
                            proc_rd_data = cache_rd_data;
                            hit_inc      = 1'b1;
                        end else begin
                            latch_req = 1'b1;
                            miss_inc  = 1'b1;
                            state_d   = MREQ;
                        end
                    end else begin
                        latch_req = 1'b1;
                        state_d   = SREQ;
                    end
                end
            end
            MREQ: begin
                proc2mem_command = CMD_LOAD;
                if (mem2proc_response != 4'd0) begin
                    pend_tag_d = mem2proc_response;
                    state_d    = MWAIT;
                end
            end
            MWAIT: begin
                if (mem2proc_tag == pend_tag_q) begin
                    cache_en      = 1'b1;
                    cache_wr_en   = 1'b1;
                    cache_wr_data = mem2proc_data;
                    proc_done     = 1'b1;
                    proc_rd_data  = mem2proc_data;
                    state_d       = IDLE;
                end
            end
            SREQ: begin
                proc2mem_command = CMD_STORE;
                if (mem2proc_response != 4'd0) begin
                    cache_en    = 1'b1;
                    cache_wr_en = 1'b1;
                    proc_done   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            pend_tag_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_tag_q <= pend_tag_d;
            if (latch_req) begin
                addr_q <= proc_addr[63:3];
                if (proc_wr)
                    data_q <= proc_wr_data;
            end
            if (hit_inc)
                hit_count_q <= hit_count_q + 32'd1;
            if (miss_inc)
                miss_count_q <= miss_count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a small direct-mapped dcachemem model.
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_req;
    logic        proc_wr;
    logic [63:0] proc_addr;
    logic [63:0] proc_wr_data;
    logic        proc_done;
    logic [63:0] proc_rd_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        cache_en;
    logic        cache_wr_en;
    logic [4:0]  cache_wr_idx;
    logic [4:0]  cache_rd_idx;
    logic [7:0]  cache_wr_tag;
    logic [7:0]  cache_rd_tag;
    logic [63:0] cache_wr_data;
    logic [63:0] cache_rd_data;
    logic        cache_rd_valid;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad = 0;

    logic [63:0] cm_data [32];
    logic [7:0]  cm_tag [32];
    logic        cm_valid [32];
    logic        cm_clr;

    always #5 clock = ~clock;

    dcache_ctrl #(.IDX_BITS(5), .TAG_BITS(8)) dut (
        .clock(clock),
        .reset(reset),
        .proc_req(proc_req),
        .proc_wr(proc_wr),
        .proc_addr(proc_addr),
        .proc_wr_data(proc_wr_data),
        .proc_done(proc_done),
        .proc_rd_data(proc_rd_data),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .cache_en(cache_en),
        .cache_wr_en(cache_wr_en),
        .cache_wr_idx(cache_wr_idx),
        .cache_rd_idx(cache_rd_idx),
        .cache_wr_tag(cache_wr_tag),
        .cache_rd_tag(cache_rd_tag),
        .cache_wr_data(cache_wr_data),
        .cache_rd_data(cache_rd_data),
        .cache_rd_valid(cache_rd_valid),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    assign cache_rd_valid = cm_valid[cache_rd_idx] &&
                            (cm_tag[cache_rd_idx] == cache_rd_tag);
    assign cache_rd_data  = cm_data[cache_rd_idx];

    always_ff @(posedge clock) begin
        if (cm_clr) begin
            for (int i = 0; i < 32; i++) begin
                cm_valid[i] <= 1'b0;
                cm_tag[i]   <= '0;
                cm_data[i]  <= '0;
            end
        end else if (cache_en && cache_wr_en) begin
            cm_valid[cache_wr_idx] <= 1'b1;
            cm_tag[cache_wr_idx]   <= cache_wr_tag;
            cm_data[cache_wr_idx]  <= cache_wr_data;
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Full load miss with immediate accept and tag two cycles later
    task automatic load_miss(input logic [63:0] a, input logic [3:0] rt,
                             input logic [63:0] d);
        cyc();
        proc_req  = 1'b1;
        proc_wr   = 1'b0;
        proc_addr = a;
        @(negedge clock);
        check("lm_idle_done", proc_done, 0);
        cyc();
        mem2proc_response = rt;
        @(negedge clock);
        check("lm_cmd", proc2mem_command, 1);
        check("lm_addr", proc2mem_addr, a);
        cyc();
        mem2proc_response = 0;
        mem2proc_tag      = rt;
        mem2proc_data     = d;
        @(negedge clock);
        check("lm_done", proc_done, 1);
        check("lm_data", proc_rd_data, d);
        cyc();
        mem2proc_tag = 0;
        proc_req     = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        cm_clr            = 1'b1;
        proc_req          = 1'b1;
        proc_wr           = 1'b0;
        proc_addr         = 64'h100;
        proc_wr_data      = 0;
        mem2proc_response = 0;
        mem2proc_tag      = 0;
        mem2proc_data     = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_done", proc_done, 0);
        check("rst_cache_en", cache_en, 0);
        check("rst_cmd", proc2mem_command, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        proc_req = 1'b0;
        reset    = 1'b0;
        cm_clr   = 1'b0;

        // cold miss at 0x100, accept tag 3, data two cycles later
        cyc();
        proc_req  = 1'b1;
        proc_addr = 64'h100;
        @(negedge clock);
        check("t1_rd_en", cache_en, 1);
        check("t1_idle_done", proc_done, 0);
        cyc();
        mem2proc_response = 3;
        @(negedge clock);
        check("t1_cmd_load", proc2mem_command, 1);
        check("t1_mem_addr", proc2mem_addr, 64'h100);
        check("t1_miss_cnt", miss_count, 1);
        cyc();
        mem2proc_response = 0;
        @(negedge clock);
        check("t1_wait_cmd", proc2mem_command, 0);
        check("t1_wait_done", proc_done, 0);
        cyc();
        mem2proc_tag  = 3;
        mem2proc_data = 64'hDEADBEEF;
        @(negedge clock);
        check("t1_fill_done", proc_done, 1);
        check("t1_fill_data", proc_rd_data, 64'hDEADBEEF);
        check("t1_fill_wr", cache_wr_en, 1);
        check("t1_fill_tag", cache_wr_tag, 1);
        cyc();
        mem2proc_tag = 0;
        @(negedge clock);
        check("t1_hit_done", proc_done, 1);
        check("t1_hit_data", proc_rd_data, 64'hDEADBEEF);
        cyc();
        proc_req = 1'b0;
        @(negedge clock);
        check("t1_hits", hit_count, 1);
        check("t1_misses", miss_count, 1);

        // rejected three times, stray tags ignored
        cyc();
        proc_req  = 1'b1;
        proc_addr = 64'h300;
        @(negedge clock);
        check("t2_idle_done", proc_done, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem2proc_response = 0;
            @(negedge clock);
            check("t2_retry_cmd", proc2mem_command, 1);
        end
        cyc();
        mem2proc_response = 5;
        mem2proc_tag      = 5;
        mem2proc_data     = 64'h1111;
        @(negedge clock);
        check("t2_accept_cmd", proc2mem_command, 1);
        check("t2_accept_done", proc_done, 0);
        cyc();
        mem2proc_response = 0;
        mem2proc_tag      = 2;
        @(negedge clock);
        check("t2_tag2_done", proc_done, 0);
        check("t2_wait_cmd", proc2mem_command, 0);
        cyc();
        mem2proc_tag = 7;
        @(negedge clock);
        check("t2_tag7_done", proc_done, 0);
        cyc();
        mem2proc_tag  = 5;
        mem2proc_data = 64'hCAFEF00D;
        @(negedge clock);
        check("t2_fill_done", proc_done, 1);
        check("t2_fill_data", proc_rd_data, 64'hCAFEF00D);
        cyc();
        mem2proc_tag = 0;
        proc_req     = 1'b0;
        @(negedge clock);
        check("t2_misses", miss_count, 2);

        // store 0x55 to 0x208 then load it back
        cyc();
        proc_req     = 1'b1;
        proc_wr      = 1'b1;
        proc_addr    = 64'h208;
        proc_wr_data = 64'h55;
        @(negedge clock);
        check("t3_idle_en", cache_en, 0);
        check("t3_idle_done", proc_done, 0);
        cyc();
        mem2proc_response = 1;
        @(negedge clock);
        check("t3_cmd_store", proc2mem_command, 2);
        check("t3_mem_addr", proc2mem_addr, 64'h208);
        check("t3_mem_data", proc2mem_data, 64'h55);
        check("t3_done", proc_done, 1);
        check("t3_wr_data", cache_wr_data, 64'h55);
        cyc();
        mem2proc_response = 0;
        proc_wr           = 1'b0;
        @(negedge clock);
        check("t3_hit_done", proc_done, 1);
        check("t3_hit_data", proc_rd_data, 64'h55);
        cyc();
        proc_req = 1'b0;
        @(negedge clock);
        check("t3_hits", hit_count, 2);
        check("t3_misses", miss_count, 2);

        // conflict misses on index 1
        load_miss(64'h008, 4'd6, 64'hA0A0);
        load_miss(64'h108, 4'd9, 64'hB0B0);
        load_miss(64'h008, 4'd6, 64'hA0A0);
        @(negedge clock);
        check("t4_misses", miss_count, 5);
        check("t4_hits", hit_count, 2);

        // reset during MWAIT abandons the transaction
        cyc();
        proc_req  = 1'b1;
        proc_addr = 64'h400;
        @(negedge clock);
        cyc();
        mem2proc_response = 4;
        @(negedge clock);
        check("t5_cmd", proc2mem_command, 1);
        cyc();
        mem2proc_response = 0;
        proc_req          = 1'b0;
        #2;
        reset        = 1'b1;
        mem2proc_tag = 4;
        #1;
        check("t5_rst_cmd", proc2mem_command, 0);
        check("t5_rst_done", proc_done, 0);
        check("t5_rst_misses", miss_count, 0);
        check("t5_rst_hits", hit_count, 0);
        @(negedge clock);
        reset = 1'b0;
        cyc();
        @(negedge clock);
        check("t5_late_done", proc_done, 0);
        check("t5_late_wr", cache_wr_en, 0);
        cyc();
        mem2proc_tag = 0;
        proc_req     = 1'b1;
        proc_addr    = 64'h400;
        @(negedge clock);
        check("t5_nofill_en", cache_en, 1);
        check("t5_nofill_done", proc_done, 0);
        cyc();
        @(negedge clock);
        check("t5_miss_after", miss_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
